femto_clkdiv: RTL and testbench
===============================

FEMTO_CLKDIV -- requirements
Module: femto_clkdiv

Interface
REQ-001 The module SHALL have parameter NCH, default 2, number of divided-clock channels (1..8).
REQ-002 The module SHALL have parameter DIVW, default 8, divisor width in bits.
REQ-003 The module SHALL have parameter DIV_INIT, default 2, divisor loaded into every channel at reset.
REQ-004 The module SHALL have parameter LOCK_PERIODS, default 4, complete output periods required before a channel reports locked.
REQ-005 The module SHALL have parameter RST_HOLD, default 16, pclk cycles rstn_out stays low after all channels lock.
REQ-006 The module SHALL have port pclk, input, 1, sole clock, all logic rising-edge.
REQ-007 The module SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 The module SHALL have port cfg_valid, input, 1, divisor-update request.
REQ-009 The module SHALL have port cfg_ready, output, 1, update accepted when cfg_valid && cfg_ready.
REQ-010 The module SHALL have port cfg_ch, input, 3, target channel index.
REQ-011 The module SHALL have port cfg_div, input, DIVW, requested divisor.
REQ-012 The module SHALL have port clk_out, output, NCH, divided clock levels.
REQ-013 The module SHALL have port clk_en, output, NCH, one-cycle pulse on the last pclk cycle of each output period.
REQ-014 The module SHALL have port locked, output, NCH, per-channel lock status.
REQ-015 The module SHALL have port rstn_out, output, 1, downstream active-low reset, released after lock.

Function
REQ-016 Each channel SHALL hold an active divisor d; cfg_div values 0 or 1 SHALL be clamped to 2.
REQ-017 Each channel SHALL run counter cnt 0..d-1, wrapping to 0 after d-1.
REQ-018 clk_out[i] SHALL be registered and equal (cnt < floor(d/2)): d=2 gives 1-high/1-low, d=5 gives 2-high/3-low.
REQ-019 clk_en[i] SHALL be high exactly in the cycle where cnt == d-1.
REQ-020 An accepted update SHALL be stored as pending for channel cfg_ch; cfg_ch >= NCH SHALL be accepted and ignored.
REQ-021 cfg_ready SHALL equal NOT pending[cfg_ch] (1 when cfg_ch >= NCH).
REQ-022 A pending divisor SHALL become active only at the period boundary (cycle with cnt == d-1), so the next cycle starts cnt=0 under the new d; no truncated or extended high phase.
REQ-023 Applying a pending divisor SHALL clear locked[i] and pending[i] in the same edge.
REQ-024 locked[i] SHALL set on the clk_en pulse that completes LOCK_PERIODS full periods under the current divisor.
REQ-025 An update carrying the same value as the active divisor SHALL still re-run the lock sequence.
REQ-026 all_locked (internal) SHALL be AND of locked[NCH-1:0].
REQ-027 rstn_out SHALL go high RST_HOLD cycles after all_locked rises, and SHALL go low on the edge after all_locked falls, restarting the hold count.

Reset
REQ-028 While resetn is low: cnt=0, d=clamped DIV_INIT, pending=0, clk_out=0, clk_en=0, locked=0, rstn_out=0, hold counter=0.
REQ-029 Reset asserted mid-period or with updates pending SHALL discard the pending updates; after release every channel restarts from cnt=0.

Structure
REQ-030 MIN_DIV=2 and the lock/hold counter width rule ($clog2) SHALL live in a shared clock-defs header used by all clock blocks.
REQ-031 One channel SHALL be a sub-module femto_clkdiv_chan (counter, pending register, lock counter), instantiated NCH times via generate; the top holds the handshake decode and the rstn_out sequencer.

Verification
REQ-032 Reset release with DIV_INIT=2 -> clk_out[0] toggles every cycle, locked[0] rises at the end of period 4 (cycle 8), and rstn_out rises 16 cycles after both channels lock.
REQ-033 Write ch1 div=5 mid-period -> the old period completes unchanged, then the pattern is 2 high/3 low, and locked[1] falls at the switch and rises 20 cycles later.
REQ-034 Write div=0 and div=1 -> the channel behaves as div=2.
REQ-035 Second write to the same channel while pending -> cfg_ready=0 and the write is held until the boundary; a write to another channel in the same window is accepted immediately.
REQ-036 cfg_ch=7 with NCH=2 -> accepted in one cycle with no state change.
REQ-037 resetn pulsed low mid-operation with a pending update -> all outputs 0 asynchronously, and after release the pending update is lost and channels run DIV_INIT.

Source files
------------

// File: rtl/femto_clkdiv_pkg.sv
// Shared clock-block definitions: minimum legal divisor and counter sizing rule.
package femto_clkdiv_pkg;

    // Smallest divisor that still produces a real high and low phase.
    localparam int MIN_DIV = 2;

    // Bits needed for a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/femto_clkdiv_chan.sv
// One divided-clock channel: period counter, pending divisor slot, lock tracker.
module femto_clkdiv_chan
    import femto_clkdiv_pkg::*;
#(
    parameter int DIVW         = 8,
    parameter int DIV_INIT     = 2,
    parameter int LOCK_PERIODS = 4
) (
    input  logic            pclk,
    input  logic            resetn,
    input  logic            wr_en,
    input  logic [DIVW-1:0] wr_div,
    output logic            clk_out,
    output logic            clk_en,
    output logic            locked,
    output logic            pending
);

    localparam int LW = cnt_width(LOCK_PERIODS);
    localparam logic [DIVW-1:0] DIV_RST =
        (DIV_INIT < MIN_DIV) ? DIVW'(MIN_DIV) : DIVW'(DIV_INIT);

    logic [DIVW-1:0] d;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] pend_div;
    logic [DIVW-1:0] cnt_n;
    logic [DIVW-1:0] d_n;
    logic [DIVW-1:0] wr_div_c;
    logic [LW-1:0]   lock_cnt;
    logic            wrap;

    // Next counter/divisor: a pending divisor only takes over at the period boundary.
    always_comb begin
        wrap     = (cnt == d - DIVW'(1));
        wr_div_c = (wr_div < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : wr_div;
        cnt_n    = wrap ? '0 : cnt + DIVW'(1);
        d_n      = (wrap && pending) ? pend_div : d;
    end

    // Counter, registered outputs (computed from next state so they track cnt), lock and pending.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            d        <= DIV_RST;
            pend_div <= DIV_RST;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
            clk_en   <= 1'b0;
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            cnt     <= cnt_n;
            d       <= d_n;
            clk_out <= (cnt_n < (d_n >> 1));
            clk_en  <= (cnt_n == d_n - DIVW'(1));
            if (wrap && pending) begin
                // New divisor starts: lock must be re-earned, even for an identical value.
                pending  <= 1'b0;
                locked   <= 1'b0;
                lock_cnt <= '0;
            end else if (wrap && !locked) begin
                if (lock_cnt == LW'(LOCK_PERIODS - 1))
                    locked <= 1'b1;
                else
                    lock_cnt <= lock_cnt + LW'(1);
            end
            // wr_en is only granted while nothing is pending, so it never races the clear above.
            if (wr_en) begin
                pending  <= 1'b1;
                pend_div <= wr_div_c;
            end
        end
    end

endmodule

// File: rtl/femto_clkdiv.sv
// Multi-channel clock divider with config handshake and lock-gated downstream reset.
module femto_clkdiv
    import femto_clkdiv_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int DIVW         = 8,
    parameter int DIV_INIT     = 2,
    parameter int LOCK_PERIODS = 4,
    parameter int RST_HOLD     = 16   // expected >= 1
) (
    input  logic            pclk,
    input  logic            resetn,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [2:0]      cfg_ch,
    input  logic [DIVW-1:0] cfg_div,
    output logic [NCH-1:0]  clk_out,
    output logic [NCH-1:0]  clk_en,
    output logic [NCH-1:0]  locked,
    output logic            rstn_out
);

    localparam int HW = cnt_width(RST_HOLD);

    logic [NCH-1:0] pending;
    logic [NCH-1:0] wr_en;
    logic [HW-1:0]  hold_cnt;
    logic           all_locked;

    // Ready decode: busy only if the addressed channel already has an update queued.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++)
            if (cfg_ch == 3'(i)) cfg_ready = !pending[i];
    end

    // Per-channel write strobes; out-of-range channels get none, so the write is dropped.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NCH; i++)
            wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == 3'(i));
    end

    assign all_locked = &locked;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            femto_clkdiv_chan #(
                .DIVW         (DIVW),
                .DIV_INIT     (DIV_INIT),
                .LOCK_PERIODS (LOCK_PERIODS)
            ) u_chan (
                .pclk    (pclk),
                .resetn  (resetn),
                .wr_en   (wr_en[g]),
                .wr_div  (cfg_div),
                .clk_out (clk_out[g]),
                .clk_en  (clk_en[g]),
                .locked  (locked[g]),
                .pending (pending[g])
            );
        end
    endgenerate

    // Downstream reset sequencer: release after RST_HOLD locked cycles, drop as soon as lock is lost.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt <= '0;
            rstn_out <= 1'b0;
        end else if (!all_locked) begin
            hold_cnt <= '0;
            rstn_out <= 1'b0;
        end else if (!rstn_out) begin
            if (hold_cnt == HW'(RST_HOLD - 1))
                rstn_out <= 1'b1;
            else
                hold_cnt <= hold_cnt + HW'(1);
        end
    end

endmodule

// File: tb/tb_femto_clkdiv.sv
// Randomized + directed bench for femto_clkdiv against a period-position reference model.
module tb_femto_clkdiv;

    localparam int NCH  = 2;
    localparam int DIVW = 8;
    localparam int DINI = 2;
    localparam int LP   = 4;
    localparam int RH   = 16;

    logic            pclk;
    logic            resetn;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [2:0]      cfg_ch;
    logic [DIVW-1:0] cfg_div;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  clk_en;
    logic [NCH-1:0]  locked;
    logic            rstn_out;

    femto_clkdiv #(
        .NCH(NCH), .DIVW(DIVW), .DIV_INIT(DINI), .LOCK_PERIODS(LP), .RST_HOLD(RH)
    ) dut (
        .pclk(pclk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .clk_out(clk_out), .clk_en(clk_en),
        .locked(locked), .rstn_out(rstn_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel is a divisor, a position within the current
    // period, and a count of complete periods since that divisor took effect.
    int m_d   [NCH];
    int m_pos [NCH];
    int m_per [NCH];
    int m_pdiv[NCH];
    bit m_pend[NCH];
    bit e_clk [NCH];
    bit e_en  [NCH];
    int m_run;      // consecutive cycles with every channel locked

    function automatic int clampd(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic bit m_locked(input int i);
        return m_per[i] >= LP;
    endfunction

    function automatic bit m_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pend[int'(cfg_ch)];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_d[i] = clampd(DINI); m_pos[i] = 0; m_per[i] = 0;
            m_pend[i] = 0; m_pdiv[i] = 0; e_clk[i] = 0; e_en[i] = 0;
        end
        m_run = 0;
    endtask

    task automatic m_edge();
        bit acc;
        bit all;
        if (!resetn) begin
            m_reset();
            return;
        end
        acc = cfg_valid && m_ready();
        all = 1'b1;
        for (int i = 0; i < NCH; i++) all &= m_locked(i);
        for (int i = 0; i < NCH; i++) begin
            if (m_pos[i] == m_d[i] - 1) begin
                if (m_pend[i]) begin
                    m_d[i] = m_pdiv[i]; m_pend[i] = 0; m_per[i] = 0;
                end else if (m_per[i] < LP) begin
                    m_per[i]++;
                end
                m_pos[i] = 0;
            end else begin
                m_pos[i]++;
            end
            e_clk[i] = (m_pos[i] < m_d[i] / 2);
            e_en[i]  = (m_pos[i] == m_d[i] - 1);
        end
        if (acc && int'(cfg_ch) < NCH) begin
            m_pend[int'(cfg_ch)] = 1'b1;
            m_pdiv[int'(cfg_ch)] = clampd(int'(cfg_div));
        end
        m_run = all ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    endtask

    task automatic check_outs(input string tag);
        logic [NCH-1:0] ec, ee, el;
        for (int i = 0; i < NCH; i++) begin
            ec[i] = e_clk[i]; ee[i] = e_en[i]; el[i] = m_locked(i);
        end
        chk({tag, ".clk_out"}, 32'(clk_out), 32'(ec));
        chk({tag, ".clk_en"},  32'(clk_en),  32'(ee));
        chk({tag, ".locked"},  32'(locked),  32'(el));
        chk({tag, ".rstn_out"}, 32'(rstn_out), 32'(m_run >= RH));
    endtask

    // One pclk cycle: drive inputs, check ready, clock, check registered outputs.
    task automatic cycle(input string tag, input bit v, input int ch, input int dv);
        cfg_valid = v; cfg_ch = 3'(ch); cfg_div = DIVW'(dv);
        #1 chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(m_ready()));
        @(posedge pclk);
        m_edge();
        #1 check_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag, 1'b0, 0, 0);
    endtask

    // Hold a write until the model says it is accepted, bounded.
    task automatic wr(input string tag, input int ch, input int dv);
        bit done;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            done = m_ready();
            cycle(tag, 1'b1, ch, dv);
        end
        if (!done) chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        m_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge pclk);
            #1 check_outs("rst");
            chk("rst.cfg_ready", 32'(cfg_ready), 32'd1);
        end
        resetn = 1'b1;

        // Power-up: DIV_INIT=2 toggles every cycle, lock after 4 periods (edge 8),
        // rstn_out 16 cycles after both lock (edge 24).
        idle("boot", 7);
        chk("boot.lock_edge7", 32'(locked), 32'd0);
        idle("boot", 1);
        chk("boot.lock_edge8", 32'(locked), 32'd3);
        idle("boot", 15);
        chk("boot.rstn_edge23", 32'(rstn_out), 32'd0);
        idle("boot", 1);
        chk("boot.rstn_edge24", 32'(rstn_out), 32'd1);
        idle("boot", 5);

        // Divisor change mid-period, then clamping of 0 and 1.
        wr("div5", 1, 5);
        idle("div5", 40);
        wr("div0", 0, 0);
        idle("div0", 20);
        wr("div1", 0, 1);
        idle("div1", 20);
        wr("same", 1, 5);
        idle("same", 30);

        // Back-pressure on a pending channel while the other channel is free.
        idle("bp", 1);
        wr("bp.a", 1, 7);
        cycle("bp.b", 1'b1, 1, 3);
        cycle("bp.c", 1'b1, 1, 3);
        wr("bp.d", 0, 4);
        wr("bp.e", 1, 3);
        idle("bp", 40);

        // Out-of-range channel is swallowed.
        wr("ch7", 7, 9);
        idle("ch7", 10);

        // Random traffic.
        for (int k = 0; k < 2500; k++) begin
            bit v;
            int ch;
            v  = ($urandom_range(0, 29) == 0);
            ch = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1));
            cycle("rnd", v, ch, int'($urandom_range(0, 7)));
        end

        // Asynchronous reset with an update pending.
        idle("arst", 3);
        wr("arst.wr", 1, 7);
        #2 resetn = 1'b0;
        #1 m_reset();
        check_outs("arst.async");
        chk("arst.cfg_ready", 32'(cfg_ready), 32'd1);
        idle("arst.hold", 2);
        resetn = 1'b1;
        idle("arst.run", 40);

        for (int k = 0; k < 1500; k++) begin
            bit v;
            v = ($urandom_range(0, 24) == 0);
            cycle("rnd2", v, int'($urandom_range(0, 2)), int'($urandom_range(0, 9)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
